// File: rtl/tcm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tcm_arbiter_pkg
// Shared constants and types for the two-master TCM arbiter.
//   - Bus geometry (data width, access-size code width, TCM address width)
//   - Access-size codes
//   - Master identifiers (instruction fetch / data load-store)
// -----------------------------------------------------------------------------
package tcm_arbiter_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int TCM_VA_WIDTH  = 16;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Master identifiers; the value doubles as the index into per-master vectors.
  typedef enum logic {
    TCM_MST_IF = 1'b0,
    TCM_MST_D  = 1'b1
  } mst_e;

  // The master that is not m; used to rotate round-robin priority.
  function automatic mst_e other_mst(input mst_e m);
    return (m == TCM_MST_IF) ? TCM_MST_D : TCM_MST_IF;
  endfunction

endpackage

// File: rtl/tcm_arbiter_slot.sv
// -----------------------------------------------------------------------------
// tcm_arbiter_slot
// One-entry pending register holding a request that lost arbitration.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cap           load in_* fields and mark the slot valid
//   rel           slot was granted this cycle; mark it empty
//   in_*          live request fields from the master
//   out_*         captured request fields
//   vld           slot holds a request
// -----------------------------------------------------------------------------
module tcm_arbiter_slot #(
  parameter int VA_WIDTH = 16,
  parameter int DW       = 32,
  parameter int AW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap,
  input  logic                rel,
  input  logic [VA_WIDTH-1:0] in_addr,
  input  logic                in_w_rb,
  input  logic [AW-1:0]       in_acc,
  input  logic [DW-1:0]       in_wdata,
  output logic [VA_WIDTH-1:0] out_addr,
  output logic                out_w_rb,
  output logic [AW-1:0]       out_acc,
  output logic [DW-1:0]       out_wdata,
  output logic                vld
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (cap) begin
      vld <= 1'b1;
    end else if (rel) begin
      vld <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while
  // vld is set, so resetting them would add fanout on rst for no benefit.
  always_ff @(posedge clk) begin
    if (cap) begin
      out_addr  <= in_addr;
      out_w_rb  <= in_w_rb;
      out_acc   <= in_acc;
      out_wdata <= in_wdata;
    end
  end

endmodule

// File: rtl/tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_arbiter
// Two-master to one-slave arbiter in front of the TCM controller.
// Master 0 = instruction fetch, master 1 = data load/store. Uncontended
// requests pass through in the same cycle; a loser is parked in a one-entry
// slot and issued next cycle. Round-robin priority on collisions.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m{0,1}_addr/w_rb/acc/wdata  master request fields
//   m{0,1}_req                one-cycle request pulse
//   m{0,1}_rdata/resp/fault   per-master completion (rdata broadcast)
//   s_addr/w_rb/acc/wdata/req request to TCM
//   s_rdata, s_resp           registered TCM response (one cycle after req)
//   s_fault                   combinational TCM reject, same cycle as req
// -----------------------------------------------------------------------------
module tcm_arbiter
  import tcm_arbiter_pkg::*;
#(
  parameter int VA_WIDTH = TCM_VA_WIDTH,
  parameter int DW       = BUS_WIDTH,
  parameter int AW       = BUS_ACC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VA_WIDTH-1:0] m0_addr,
  input  logic                m0_w_rb,
  input  logic [AW-1:0]       m0_acc,
  input  logic [DW-1:0]       m0_wdata,
  input  logic                m0_req,
  output logic [DW-1:0]       m0_rdata,
  output logic                m0_resp,
  output logic                m0_fault,
  input  logic [VA_WIDTH-1:0] m1_addr,
  input  logic                m1_w_rb,
  input  logic [AW-1:0]       m1_acc,
  input  logic [DW-1:0]       m1_wdata,
  input  logic                m1_req,
  output logic [DW-1:0]       m1_rdata,
  output logic                m1_resp,
  output logic                m1_fault,
  output logic [VA_WIDTH-1:0] s_addr,
  output logic                s_w_rb,
  output logic [AW-1:0]       s_acc,
  output logic [DW-1:0]       s_wdata,
  output logic                s_req,
  input  logic [DW-1:0]       s_rdata,
  input  logic                s_resp,
  input  logic                s_fault
);

  logic [1:0] live_req;
  logic [1:0] pend_vld;
  logic [1:0] eff;
  logic [1:0] gnt;
  logic [1:0] cap;
  logic [1:0] rel;
  mst_e       gnt_id;
  mst_e       rr;
  logic       own_vld;
  mst_e       own_id;

  logic [VA_WIDTH-1:0] p0_addr, p1_addr, src0_addr, src1_addr;
  logic                p0_w_rb, p1_w_rb, src0_w_rb, src1_w_rb;
  logic [AW-1:0]       p0_acc, p1_acc, src0_acc, src1_acc;
  logic [DW-1:0]       p0_wdata, p1_wdata, src0_wdata, src1_wdata;

  assign live_req = {m1_req, m0_req};

  // A parked request takes precedence over the live inputs; a live req while
  // the slot is full breaks the master contract and is dropped here.
  assign eff = rst ? 2'b00 : (pend_vld | live_req);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_id = TCM_MST_IF;
    if (eff == 2'b11) begin
      gnt_id = rr;
    end else if (eff[1]) begin
      gnt_id = TCM_MST_D;
    end
  end

  assign gnt[0] = eff[0] & (gnt_id == TCM_MST_IF);
  assign gnt[1] = eff[1] & (gnt_id == TCM_MST_D);

  // Capture only a live loser into an empty slot; release a granted slot.
  assign cap = live_req & ~gnt & ~pend_vld & {2{~rst}};
  assign rel = pend_vld & gnt;

  tcm_arbiter_slot #(.VA_WIDTH(VA_WIDTH), .DW(DW), .AW(AW)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap[0]),
    .rel       (rel[0]),
    .in_addr   (m0_addr),
    .in_w_rb   (m0_w_rb),
    .in_acc    (m0_acc),
    .in_wdata  (m0_wdata),
    .out_addr  (p0_addr),
    .out_w_rb  (p0_w_rb),
    .out_acc   (p0_acc),
    .out_wdata (p0_wdata),
    .vld       (pend_vld[0])
  );

  tcm_arbiter_slot #(.VA_WIDTH(VA_WIDTH), .DW(DW), .AW(AW)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap[1]),
    .rel       (rel[1]),
    .in_addr   (m1_addr),
    .in_w_rb   (m1_w_rb),
    .in_acc    (m1_acc),
    .in_wdata  (m1_wdata),
    .out_addr  (p1_addr),
    .out_w_rb  (p1_w_rb),
    .out_acc   (p1_acc),
    .out_wdata (p1_wdata),
    .vld       (pend_vld[1])
  );

  assign src0_addr  = pend_vld[0] ? p0_addr  : m0_addr;
  assign src0_w_rb  = pend_vld[0] ? p0_w_rb  : m0_w_rb;
  assign src0_acc   = pend_vld[0] ? p0_acc   : m0_acc;
  assign src0_wdata = pend_vld[0] ? p0_wdata : m0_wdata;
  assign src1_addr  = pend_vld[1] ? p1_addr  : m1_addr;
  assign src1_w_rb  = pend_vld[1] ? p1_w_rb  : m1_w_rb;
  assign src1_acc   = pend_vld[1] ? p1_acc   : m1_acc;
  assign src1_wdata = pend_vld[1] ? p1_wdata : m1_wdata;

  // gnt_id defaults to master 0 when idle, so the idle bus shows master 0.
  assign s_req   = |eff;
  assign s_addr  = (gnt_id == TCM_MST_D) ? src1_addr  : src0_addr;
  assign s_w_rb  = (gnt_id == TCM_MST_D) ? src1_w_rb  : src0_w_rb;
  assign s_acc   = (gnt_id == TCM_MST_D) ? src1_acc   : src0_acc;
  assign s_wdata = (gnt_id == TCM_MST_D) ? src1_wdata : src0_wdata;

  // Priority rotates only on an actual collision; owner tracks the one
  // accepted transaction in flight so its response returns to the issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr      <= TCM_MST_IF;
      own_vld <= 1'b0;
      own_id  <= TCM_MST_IF;
    end else begin
      if (eff == 2'b11) begin
        rr <= other_mst(rr);
      end
      own_vld <= s_req & ~s_fault;
      own_id  <= gnt_id;
    end
  end

  assign m0_fault = s_fault & gnt[0];
  assign m1_fault = s_fault & gnt[1];
  assign m0_resp  = ~rst & s_resp & own_vld & (own_id == TCM_MST_IF);
  assign m1_resp  = ~rst & s_resp & own_vld & (own_id == TCM_MST_D);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcm_arbiter
// Directed per-cycle vector table plus a fairness sequence, driven against a
// small pipelined TCM model (registered read/resp, combinational alignment
// fault).
// -----------------------------------------------------------------------------
module tb_tcm_arbiter;
  import tcm_arbiter_pkg::*;

  localparam int VA = TCM_VA_WIDTH;
  localparam int DW = BUS_WIDTH;
  localparam int AW = BUS_ACC_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic [VA-1:0] m0_addr, m1_addr, s_addr;
  logic          m0_w_rb, m1_w_rb, s_w_rb;
  logic [AW-1:0] m0_acc, m1_acc, s_acc;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
  logic          m0_req, m1_req, s_req;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_resp, m1_resp, m0_fault, m1_fault;
  logic [DW-1:0] s_rdata = '0;
  logic          s_resp = 1'b0;
  logic          s_fault;

  always #5 clk = ~clk;

  tcm_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata),
    .m0_req(m0_req), .m0_rdata(m0_rdata), .m0_resp(m0_resp), .m0_fault(m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata),
    .m1_req(m1_req), .m1_rdata(m1_rdata), .m1_resp(m1_resp), .m1_fault(m1_fault),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_req(s_req), .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
  );

  // ---------------- TCM model ----------------
  logic [DW-1:0] mem [64];

  function automatic logic misaligned(input logic [VA-1:0] a, input logic [AW-1:0] acc);
    return ((acc == BUS_ACC_2B) && a[0]) || ((acc == BUS_ACC_4B) && (a[1:0] != 2'b00));
  endfunction

  assign s_fault = s_req && misaligned(s_addr, s_acc);

  always @(posedge clk) begin
    s_resp  <= s_req & ~s_fault;
    s_rdata <= mem[s_addr[7:2]];
    if (s_req && !s_fault && s_w_rb) mem[s_addr[7:2]] <= s_wdata;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          r0; logic w0; logic [VA-1:0] a0; logic [AW-1:0] c0; logic [DW-1:0] d0;
    logic          r1; logic w1; logic [VA-1:0] a1; logic [AW-1:0] c1; logic [DW-1:0] d1;
    logic          e_sreq; logic [VA-1:0] e_saddr;
    logic          e_r0; logic e_r1; logic e_f0; logic e_f1;
    logic          chk_rd; logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0, input logic [VA-1:0] a0, input logic [AW-1:0] c0, input logic [DW-1:0] d0,
    input logic r1, input logic w1, input logic [VA-1:0] a1, input logic [AW-1:0] c1, input logic [DW-1:0] d1,
    input logic esr, input logic [VA-1:0] esa,
    input logic er0, input logic er1, input logic ef0, input logic ef1,
    input logic crd, input logic [DW-1:0] erd);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.c0 = c0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.c1 = c1; v.d1 = d1;
    v.e_sreq = esr; v.e_saddr = esa;
    v.e_r0 = er0; v.e_r1 = er1; v.e_f0 = ef0; v.e_f1 = ef1;
    v.chk_rd = crd; v.e_rd = erd;
    return v;
  endfunction

  task automatic drive_idle();
    m0_req = 0; m0_w_rb = 0; m0_addr = '0; m0_acc = BUS_ACC_4B; m0_wdata = '0;
    m1_req = 0; m1_w_rb = 0; m1_addr = '0; m1_acc = BUS_ACC_4B; m1_wdata = '0;
  endtask

  localparam logic [1:0] A4 = BUS_ACC_4B;
  localparam logic [1:0] A2 = BUS_ACC_2B;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    rst = 1'b1;
    drive_idle();

    //           rst r0 w0 a0     c0  d0   r1 w1 a1     c1  d1            sreq saddr   r0 r1 f0 f1 crd rd
    // reset, then a request during reset is ignored
    vq.push_back(mk(1, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    vq.push_back(mk(1, 1,0,16'h10,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    // solo read
    vq.push_back(mk(0, 1,0,16'h10,A4,0,    0,0,16'h00,A4,0,             1,16'h10,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    1,0,0,0, 1,32'hA000_0004));
    // collision, rr=0: m0 first, m1 from slot
    vq.push_back(mk(0, 1,0,16'h14,A4,0,    1,0,16'h18,A4,0,             1,16'h14,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             1,16'h18,    1,0,0,0, 1,32'hA000_0005));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,1,0,0, 1,32'hA000_0006));
    // collision, rr=1: m1 misaligned write wins live and faults
    vq.push_back(mk(0, 1,0,16'h10,A4,0,    1,1,16'h03,A2,32'h5555_5555, 1,16'h03,    0,0,0,1, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             1,16'h10,    0,0,0,0, 0,0));
    // collision, rr=0: m0 wins, m1 faulting write issued from its slot
    vq.push_back(mk(0, 1,0,16'h1C,A4,0,    1,1,16'h03,A2,32'h6666_6666, 1,16'h1C,    1,0,0,0, 1,32'hA000_0004));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             1,16'h03,    1,0,0,1, 1,32'hA000_0007));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    // pipelined write then read of the same word
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    1,1,16'h20,A4,32'hDEAD_BEEF, 1,16'h20,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 1,0,16'h20,A4,0,    0,0,16'h00,A4,0,             1,16'h20,    0,1,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    1,0,0,0, 1,32'hDEAD_BEEF));
    // collision (rr=1 -> m1 first), then reset drops in-flight and parked
    vq.push_back(mk(0, 1,0,16'h24,A4,0,    1,0,16'h28,A4,0,             1,16'h28,    0,0,0,0, 0,0));
    vq.push_back(mk(1, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,0,0,0, 0,0));
    // rr back to 0 after reset: m0 wins
    vq.push_back(mk(0, 1,0,16'h24,A4,0,    1,0,16'h28,A4,0,             1,16'h24,    0,0,0,0, 0,0));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             1,16'h28,    1,0,0,0, 1,32'hA000_0009));
    vq.push_back(mk(0, 0,0,16'h00,A4,0,    0,0,16'h00,A4,0,             0,16'h00,    0,1,0,0, 1,32'hA000_000A));

    foreach (vq[k]) begin
      @(posedge clk); #1;
      rst = vq[k].rst;
      m0_req = vq[k].r0; m0_w_rb = vq[k].w0; m0_addr = vq[k].a0; m0_acc = vq[k].c0; m0_wdata = vq[k].d0;
      m1_req = vq[k].r1; m1_w_rb = vq[k].w1; m1_addr = vq[k].a1; m1_acc = vq[k].c1; m1_wdata = vq[k].d1;
      @(negedge clk);
      check($sformatf("v%0d s_req", k), 32'(s_req), 32'(vq[k].e_sreq));
      if (vq[k].e_sreq) check($sformatf("v%0d s_addr", k), 32'(s_addr), 32'(vq[k].e_saddr));
      check($sformatf("v%0d m0_resp", k), 32'(m0_resp), 32'(vq[k].e_r0));
      check($sformatf("v%0d m1_resp", k), 32'(m1_resp), 32'(vq[k].e_r1));
      check($sformatf("v%0d m0_fault", k), 32'(m0_fault), 32'(vq[k].e_f0));
      check($sformatf("v%0d m1_fault", k), 32'(m1_fault), 32'(vq[k].e_f1));
      if (vq[k].chk_rd) begin
        check($sformatf("v%0d m0_rdata", k), m0_rdata, vq[k].e_rd);
        check($sformatf("v%0d m1_rdata", k), m1_rdata, vq[k].e_rd);
      end
    end

    // Fairness: both masters re-request in the cycle they see their resp.
    // rr is 1 here (one collision since reset), so m1 wins the first round
    // and grants must alternate every cycle afterwards.
    begin
      logic exp_g;
      logic prev_g;
      int   issues0, issues1;
      exp_g = 1'b1; prev_g = 1'b0; issues0 = 0; issues1 = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        m0_addr = 16'h30; m0_w_rb = 0; m0_acc = A4;
        m1_addr = 16'h34; m1_w_rb = 0; m1_acc = A4;
        m0_req = (c == 0) || m0_resp;
        m1_req = (c == 0) || m1_resp;
        @(negedge clk);
        check($sformatf("fair c%0d s_req", c), 32'(s_req), 32'd1);
        check($sformatf("fair c%0d grant", c), 32'(s_addr), exp_g ? 32'h34 : 32'h30);
        if (c > 0) begin
          check($sformatf("fair c%0d resp", c), 32'(prev_g ? m1_resp : m0_resp), 32'd1);
          check($sformatf("fair c%0d rdata", c), m0_rdata,
                prev_g ? 32'hA000_000D : 32'hA000_000C);
        end
        if (s_addr == 16'h30) issues0++;
        if (s_addr == 16'h34) issues1++;
        prev_g = exp_g;
        exp_g  = ~exp_g;
      end
      check("fair m0 issues", 32'(issues0), 32'd8);
      check("fair m1 issues", 32'(issues1), 32'd8);
      @(posedge clk); #1;
      drive_idle();
      repeat (3) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
